// File: rtl/data_bus_uart_tx.sv
// data_bus_uart_tx: data-bus mapped 8N1 UART transmitter with a small byte FIFO; UART_TX_IRQ_EN adds irq and IRQ_ENABLE at 0xC
module data_bus_uart_tx #(
    parameter logic [31:0] BASE_ADDRESS = 32'h8000_1000,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_DIVISOR = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enable,
    input  logic        read_enable,
    input  logic        write_enable,
    output logic [31:0] read_data,
`ifdef UART_TX_IRQ_EN
    output logic        irq,
`endif
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);
    localparam logic [15:0] RST_DIV = 16'(RESET_DIVISOR);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state, state_next;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [4:0] count;
    logic overflow;
    logic [15:0] divisor, frame_div, cnt, div_wr;
    logic [7:0] shift, shift_next;
    logic [2:0] bit_idx;
    logic [1:0] offset;
    logic [31:0] status, reg_c;
    logic hit, wr_hit, full, empty, push, pop, accept, ovf_set, ovf_clr, bit_end, tx_next;
    logic unused;

    assign unused = ^{address[1:0], write_data[31:16], byte_enable[3:2]};

    assign hit = address[31:4] == BASE_ADDRESS[31:4];
    assign offset = address[3:2];
    assign wr_hit = write_enable && hit;
    assign full = count == DEPTH;
    assign empty = count == 5'd0;
    assign push = wr_hit && offset == 2'd0 && byte_enable[0];
    assign accept = push && (!full || pop);
    assign ovf_set = push && full && !pop;
    assign ovf_clr = wr_hit && offset == 2'd1 && byte_enable[0] && write_data[3];
    assign bit_end = cnt == 16'd0;
    assign div_wr = {byte_enable[1] ? write_data[15:8] : divisor[15:8],
                     byte_enable[0] ? write_data[7:0] : divisor[7:0]};
    assign status = {19'b0, count, 4'b0, overflow, state != IDLE, empty, full};
    assign read_data = !(read_enable && hit) ? 32'b0 :
                       offset == 2'd1 ? status :
                       offset == 2'd2 ? {16'b0, divisor} :
                       offset == 2'd3 ? reg_c : 32'b0;

    // next state; the head byte is popped on entry to START
    always_comb begin
        state_next = state;
        pop = 1'b0;
        case (state)
            IDLE: if (!empty) begin pop = 1'b1; state_next = START; end
            START: if (bit_end) state_next = DATA;
            DATA: if (bit_end && bit_idx == 3'd7) state_next = STOP;
            default: if (bit_end) begin pop = !empty; state_next = empty ? IDLE : START; end
        endcase
    end

    assign shift_next = pop ? mem[rd_ptr] : (state == DATA && bit_end) ? shift >> 1 : shift;
    assign tx_next = state_next == START ? 1'b0 : state_next == DATA ? shift_next[0] : 1'b1;

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    // FIFO storage needs no reset: the pointers and count define validity
    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr] <= write_data[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow (a set wins over a clear)
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr <= accept ? wr_ptr + AW'(1) : wr_ptr;
            count <= count + {4'b0, accept} - {4'b0, pop};
            overflow <= ovf_set ? 1'b1 : ovf_clr ? 1'b0 : overflow;
        end
    end

    // DIVISOR register; zero would stall the bit timer so it is stored as 1
    always_ff @(posedge clock) begin
        if (reset) divisor <= RST_DIV;
        else if (wr_hit && offset == 2'd2) divisor <= div_wr == 16'd0 ? 16'd1 : div_wr;
    end

    // bit timer, bit index, shifter and registered line; frame_div freezes the width per frame
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_div <= RST_DIV;
            cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
            tx <= 1'b1;
        end else begin
            frame_div <= pop ? divisor : frame_div;
            cnt <= pop ? divisor - 16'd1 : state == IDLE ? cnt : bit_end ? frame_div - 16'd1 : cnt - 16'd1;
            bit_idx <= state == START ? 3'd0 : (state == DATA && bit_end) ? bit_idx + 3'd1 : bit_idx;
            shift <= shift_next;
            tx <= tx_next;
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en;

    // irq flags a drained, idle transmitter one cycle after the fact
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq <= 1'b0;
        end else begin
            irq_en <= (wr_hit && offset == 2'd3 && byte_enable[0]) ? write_data[0] : irq_en;
            irq <= irq_en && empty && state == IDLE;
        end
    end

    assign reg_c = {31'b0, irq_en};
`else
    assign reg_c = 32'b0;
`endif
endmodule

// File: tb/tb_data_bus_uart_tx.sv
// tb_data_bus_uart_tx: random and directed bus traffic, transaction-level model, scoreboarded line monitor
module tb_data_bus_uart_tx;
    localparam logic [31:0] BASE = 32'h8000_1000;
    localparam int DEPTH = 4;
    localparam int RDIV = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [3:0] byte_enable = '0;
    logic read_enable = 1'b0;
    logic write_enable = 1'b0;
    logic [31:0] read_data;
    logic tx;
`ifdef UART_TX_IRQ_EN
    logic irq;
`endif

    data_bus_uart_tx #(.BASE_ADDRESS(BASE), .FIFO_DEPTH(DEPTH), .RESET_DIVISOR(RDIV)) dut (
        .clock(clock),
        .reset(reset),
        .address(address),
        .write_data(write_data),
        .byte_enable(byte_enable),
        .read_enable(read_enable),
        .write_enable(write_enable),
        .read_data(read_data),
`ifdef UART_TX_IRQ_EN
        .irq(irq),
`endif
        .tx(tx)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {logic [7:0] b; int d; bit bb;} fr_t;
    fr_t sb[$];
    logic [7:0] mq[$];
    logic [15:0] m_div = 16'(RDIV);
    logic [15:0] m_nd;
    bit m_busy = 0, m_ovf = 0, m_irqen = 0, m_irq = 0, m_irq_nx, m_hit, m_pop, m_bb, m_push, m_full;
    logic [1:0] m_off;
    longint cyc = 0, m_end = 0;
    int abort_cnt = 0;
    fr_t m_fr;

    always @(posedge clock) begin
        cyc++;
        m_irq_nx = m_irqen && mq.size() == 0 && !m_busy;
        if (reset) begin
            mq.delete();
            sb.delete();
            m_busy = 0;
            m_div = 16'(RDIV);
            m_ovf = 0;
            m_irqen = 0;
            m_irq = 0;
            abort_cnt++;
        end else begin
            m_irq = m_irq_nx;
            m_hit = write_enable && address[31:4] == BASE[31:4];
            m_off = address[3:2];
            m_pop = 0;
            m_bb = 0;
            if (m_busy && cyc == m_end) begin
                if (mq.size() > 0) begin m_pop = 1; m_bb = 1; end
                else m_busy = 0;
            end else if (!m_busy && mq.size() > 0) m_pop = 1;
            m_push = m_hit && m_off == 2'd0 && byte_enable[0];
            m_full = mq.size() == DEPTH;
            if (m_pop) begin
                m_fr.b = mq.pop_front();
                m_fr.d = int'(m_div);
                m_fr.bb = m_bb;
                sb.push_back(m_fr);
                m_busy = 1;
                m_end = cyc + 10 * m_div;
            end
            if (m_hit && m_off == 2'd1 && byte_enable[0] && write_data[3]) m_ovf = 0;
            if (m_push) begin
                if (!m_full || m_pop) mq.push_back(write_data[7:0]);
                else m_ovf = 1;
            end
            if (m_hit && m_off == 2'd2) begin
                m_nd = {byte_enable[1] ? write_data[15:8] : m_div[15:8], byte_enable[0] ? write_data[7:0] : m_div[7:0]};
                m_div = m_nd == 0 ? 16'd1 : m_nd;
            end
`ifdef UART_TX_IRQ_EN
            if (m_hit && m_off == 2'd3 && byte_enable[0]) m_irqen = write_data[0];
`endif
        end
    end

    function automatic logic [31:0] model_reg(input logic [31:0] a);
        logic [4:0] n;
        n = 5'(mq.size());
        if (a[31:4] != BASE[31:4]) return 32'b0;
        case (a[3:2])
            2'd1: return {19'b0, n, 4'b0, m_ovf, m_busy, n == 5'd0, n == 5'(DEPTH)};
            2'd2: return {16'b0, m_div};
            2'd3: return {31'b0, m_irqen};
            default: return 32'b0;
        endcase
    endfunction

    // ---------------- line monitor / scoreboard ----------------
    initial begin : monitor
        fr_t e;
        int gap, ab, bad, k;
        bit lv, abort;
        gap = 1000;
        forever begin
            @(negedge clock);
            if (tx === 1'b0) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame: tx low with no frame expected at %0t", $time);
                    k = 0;
                    while (tx === 1'b0 && k < 1000) begin @(negedge clock); k++; end
                    gap = 1000;
                end else begin
                    e = sb.pop_front();
                    ab = abort_cnt;
                    abort = 0;
                    if (e.bb) chk("frame_gap", gap, 0);
                    for (int i = 0; i < 10 && !abort; i++) begin
                        lv = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : e.b[i-1];
                        bad = 0;
                        for (int c = 0; c < e.d && !abort; c++) begin
                            if (i != 0 || c != 0) @(negedge clock);
                            if (abort_cnt != ab) abort = 1;
                            else if (tx !== lv) bad++;
                        end
                        if (!abort) chk($sformatf("frame_%02h_bit%0d_badcycles", e.b, i), bad, 0);
                    end
                    gap = abort ? 1000 : 0;
                end
            end else gap++;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- bus tasks ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        address = a;
        write_data = d;
        byte_enable = be;
        write_enable = 1'b1;
        read_enable = 1'b0;
        @(posedge clock);
    endtask

    task automatic idle();
        @(negedge clock);
        write_enable = 1'b0;
        read_enable = 1'b0;
        byte_enable = '0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clock);
        write_enable = 1'b0;
        address = a;
        read_enable = 1'b1;
        #1;
        chk(nm, read_data, exp);
        read_enable = 1'b0;
    endtask

    task automatic rdm(input string nm, input logic [31:0] a);
        @(negedge clock);
        write_enable = 1'b0;
        address = a;
        read_enable = 1'b1;
        #1;
        chk(nm, read_data, model_reg(a));
        read_enable = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 0;
        for (int k = 0; k < 20000 && !ok; k++) begin
            @(negedge clock);
            ok = !m_busy && mq.size() == 0 && sb.size() == 0;
        end
        chk(nm, ok, 1);
        repeat (3) @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int k;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_tx", tx, 1);
        rd("reset_txdata", BASE, 32'h0);
        rd("reset_status", BASE + 4, 32'h2);
        rd("reset_divisor", BASE + 8, 32'h10);
        rd("reset_reg_c", BASE + 12, 32'h0);
`ifdef UART_TX_IRQ_EN
        chk("reset_irq", irq, 0);
`endif

        // single 0xA5 frame at divisor 4, start-bit latency
        wr(BASE + 8, 32'h4, 4'h3);
        wr(BASE, 32'hA5, 4'h1);
        idle();
        chk("latency_edge_n", tx, 1);
        @(negedge clock);
        chk("latency_edge_n1", tx, 0);
        rd("status_busy", BASE + 4, 32'h6);
        wait_idle("drain_a5");
        rd("status_after_a5", BASE + 4, 32'h2);

        // burst of six at divisor 2: one pops, four queue, sixth overflows
        wr(BASE + 8, 32'h2, 4'h3);
        idle();
        for (int i = 0; i < 6; i++) wr(BASE, 32'(8'h30 + i), 4'h1);
        idle();
        rd("status_full_ovf", BASE + 4, 32'h40D);
        wr(BASE + 4, 32'h8, 4'h1);
        idle();
        rd("status_ovf_cleared", BASE + 4, 32'h405);
        wait_idle("drain_burst");

        // misses: no read data, no side effects
        rd("miss_read", BASE + 32'h100, 32'h0);
        wr(BASE - 4, 32'h0000_0055, 4'hF);
        wr(BASE + 32'h10, 32'h0000_0077, 4'hF);
        idle();
        rd("miss_status", BASE + 4, 32'h2);
        rd("miss_divisor", BASE + 8, 32'h2);

        // zero divisor and mid-frame divisor change
        wr(BASE + 8, 32'h0, 4'h3);
        idle();
        rd("divisor_zero", BASE + 8, 32'h1);
        wr(BASE + 8, 32'h2, 4'h3);
        wr(BASE, 32'hC3, 4'h1);
        wr(BASE, 32'h5A, 4'h1);
        idle();
        repeat (5) @(negedge clock);
        wr(BASE + 8, 32'h8, 4'h3);
        idle();
        rd("divisor_eight", BASE + 8, 32'h8);
        wait_idle("drain_divchange");

        // reset during DATA bit 3 with two bytes queued
        wr(BASE + 8, 32'h4, 4'h3);
        wr(BASE, 32'h96, 4'h1);
        wr(BASE, 32'h11, 4'h1);
        wr(BASE, 32'h22, 4'h1);
        idle();
        rdm("status_before_reset", BASE + 4);
        repeat (16) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_tx", tx, 1);
        rd("abort_status", BASE + 4, 32'h2);
        rd("abort_divisor", BASE + 8, 32'h10);
        repeat (120) @(negedge clock);
        chk("abort_quiet_tx", tx, 1);

        // randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 9);
            if (k < 5) wr(BASE, $urandom, 4'h1);
            else if (k == 5) wr(BASE + 8, $urandom_range(0, 3), 4'h3);
            else if (k == 6) wr(BASE + 4, 32'h8, 4'h1);
            else if (k == 7) wr(BASE + 32'h20 + 32'($urandom_range(0, 3) << 2), $urandom, 4'hF);
            else rdm("rand_read", BASE + 32'($urandom_range(0, 3) << 2));
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(1, 30)) @(negedge clock);
            end
        end
        idle();
        rdm("rand_status_end", BASE + 4);
        wait_idle("drain_random");
        rdm("rand_status_idle", BASE + 4);

`ifdef UART_TX_IRQ_EN
        wr(BASE + 12, 32'h1, 4'h1);
        wr(BASE + 8, 32'h1, 4'h3);
        idle();
        rdm("irq_enable_read", BASE + 12);
        repeat (2) @(negedge clock);
        chk("irq_idle_high", irq, 1);
        wr(BASE, 32'h3C, 4'h1);
        idle();
        for (int i = 0; i < 16; i++) begin
            chk("irq_track", irq, m_irq);
            @(negedge clock);
        end
        chk("irq_after_frame", irq, 1);
        wait_idle("drain_irq");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
